// File: rtl/vga_fb_ctrl_if.sv
// Pixel write port between the game/CPU side and the frame buffer controller.
// The game side is the master and the controller is the slave.
interface vga_fb_ctrl_if;
    logic        iWR_VALID;
    logic        oWR_READY;
    logic [7:0]  iWR_X;
    logic [7:0]  iWR_Y;
    logic [11:0] iWR_RGB;

    modport master (output iWR_VALID, output iWR_X, output iWR_Y, output iWR_RGB, input oWR_READY);
    modport slave  (input iWR_VALID, input iWR_X, input iWR_Y, input iWR_RGB, output oWR_READY);
endinterface

// File: rtl/vga_fb_ctrl.sv
// Double-buffered 256x256 RGB444 frame buffer. Writes and clears go to the back bank,
// display reads come from the front bank, and banks swap only on frame start.
module vga_fb_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CLR_W      = 16
) (
    input  logic         iCLK,
    input  logic         iRST,
    vga_fb_ctrl_if.slave wr,
    input  logic         iCLEAR_REQ,
    input  logic [11:0]  iCLEAR_RGB,
    input  logic         iSWAP_REQ,
    input  logic         iFRAME_START,
    input  logic         iRD_EN,
    input  logic [7:0]   iRD_X,
    input  logic [7:0]   iRD_Y,
    output logic         oRD_VALID,
    output logic [9:0]   oPIX_R,
    output logic [9:0]   oPIX_G,
    output logic [9:0]   oPIX_B,
    output logic         oSWAP_DONE,
    output logic         oBUSY
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t state, state_next;

    logic [11:0]      fifo_rgb  [FIFO_DEPTH];
    logic [CLR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full, empty, push, pop;

    logic             wq_valid;
    logic [CLR_W-1:0] wq_addr;
    logic [11:0]      wq_rgb;

    logic [CLR_W-1:0] clr_addr;
    logic [11:0]      clr_rgb;
    logic             clr_pend, clr_we, clr_last;
    logic             swap_pend, swap_go, swap_done, front_sel;

    logic [11:0]      mem [0:(1<<(CLR_W+1))-1];
    logic             mem_we;
    logic [CLR_W:0]   mem_addr;
    logic [11:0]      mem_data;
    logic [11:0]      rd_word;
    logic             rd_v1;

    function automatic logic [9:0] expand(input logic [3:0] c);
        return {c, c, c[3:2]};
    endfunction

    assign full          = (count == DEPTH_C);
    assign empty         = (count == '0);
    assign wr.oWR_READY  = !full && !clr_pend && (state != CLEAR);
    assign push          = wr.iWR_VALID && wr.oWR_READY;
    assign oSWAP_DONE    = swap_done;
    assign oBUSY         = clr_pend || (state == CLEAR) || !empty || wq_valid;

    // A swap needs every pending pixel already in the back bank.
    assign swap_go = iFRAME_START && (swap_pend || iSWAP_REQ) && empty && !wq_valid
                     && (state == IDLE) && !clr_pend;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        clr_we     = 1'b0;
        clr_last   = 1'b0;
        case (state)
            IDLE: begin
                pop = !empty;
                if (clr_pend && empty && !wq_valid)
                    state_next = CLEAR;
            end
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_addr == '1) begin
                    clr_last   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= IDLE;
            clr_addr  <= '0;
            clr_pend  <= 1'b0;
            clr_rgb   <= '0;
            swap_pend <= 1'b0;
            front_sel <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next == CLEAR)
                clr_addr <= '0;
            else if (clr_we)
                clr_addr <= clr_addr + 1'b1;
            if (clr_last)
                clr_pend <= 1'b0;
            if (iCLEAR_REQ && state != CLEAR) begin
                clr_pend <= 1'b1;
                clr_rgb  <= iCLEAR_RGB;
            end
            swap_done <= swap_go;
            if (swap_go) begin
                front_sel <= ~front_sel;
                swap_pend <= 1'b0;
            end else if (iSWAP_REQ) begin
                swap_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wq_valid <= 1'b0;
            wq_addr  <= '0;
            wq_rgb   <= '0;
        end else begin
            if (push) begin
                fifo_rgb[wr_ptr]  <= wr.iWR_RGB;
                fifo_addr[wr_ptr] <= {wr.iWR_Y, wr.iWR_X};
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                wq_addr <= fifo_addr[rd_ptr];
                wq_rgb  <= fifo_rgb[rd_ptr];
            end
            wq_valid <= pop;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Clear and FIFO writes never overlap, so one write port serves both.
    always_comb begin
        mem_we   = (clr_we || wq_valid) && !iRST;
        mem_addr = {~front_sel, wq_addr};
        mem_data = wq_rgb;
        if (clr_we) begin
            mem_addr = {~front_sel, clr_addr};
            mem_data = clr_rgb;
        end
    end

    always_ff @(posedge iCLK) begin
        if (mem_we)
            mem[mem_addr] <= mem_data;
        rd_word <= mem[{front_sel, iRD_Y, iRD_X}];
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rd_v1     <= 1'b0;
            oRD_VALID <= 1'b0;
            oPIX_R    <= '0;
            oPIX_G    <= '0;
            oPIX_B    <= '0;
        end else begin
            rd_v1     <= iRD_EN;
            oRD_VALID <= rd_v1;
            if (rd_v1) begin
                oPIX_R <= expand(rd_word[11:8]);
                oPIX_G <= expand(rd_word[7:4]);
                oPIX_B <= expand(rd_word[3:0]);
            end else begin
                oPIX_R <= '0;
                oPIX_G <= '0;
                oPIX_B <= '0;
            end
        end
    end
endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Bench for vga_fb_ctrl: constant vector table, corner-case sequences and
// randomized writes/reads checked against a two-bank array model.
module tb_vga_fb_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_req = 1'b0, swap_req = 1'b0, frame_start = 1'b0, rd_en = 1'b0;
    logic [11:0] clear_rgb = '0;
    logic [7:0]  rd_x = '0, rd_y = '0;
    logic        rd_valid, swap_done, busy;
    logic [9:0]  pix_r, pix_g, pix_b;

    always #5 clk = ~clk;

    vga_fb_ctrl_if wr_if();

    vga_fb_ctrl #(.FIFO_DEPTH(4), .CLR_W(16)) dut (
        .iCLK(clk), .iRST(rst), .wr(wr_if),
        .iCLEAR_REQ(clear_req), .iCLEAR_RGB(clear_rgb),
        .iSWAP_REQ(swap_req), .iFRAME_START(frame_start),
        .iRD_EN(rd_en), .iRD_X(rd_x), .iRD_Y(rd_y),
        .oRD_VALID(rd_valid), .oPIX_R(pix_r), .oPIX_G(pix_g), .oPIX_B(pix_b),
        .oSWAP_DONE(swap_done), .oBUSY(busy)
    );

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [11:0] rgb;
        logic [29:0] pix;
    } vec_t;

    int unsigned n_vec = 0, n_bad = 0;
    logic [11:0] mdl [2][65536];
    int          mfront = 0;
    logic [7:0]  qx[$], qy[$];

    function automatic logic [9:0] ref_exp(input logic [3:0] c);
        int v = int'(c);
        return 10'(v * 68 + v / 4);
    endfunction

    function automatic logic [29:0] exp_pix(input logic [11:0] rgb);
        return {ref_exp(rgb[11:8]), ref_exp(rgb[7:4]), ref_exp(rgb[3:0])};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_ready"}, 32'(wr_if.oWR_READY), 1);
        chk({name, "_busy"}, 32'(busy), 0);
        chk({name, "_valid"}, 32'(rd_valid), 0);
        chk({name, "_pix"}, 32'({pix_r, pix_g, pix_b}), 0);
        chk({name, "_swapdone"}, 32'(swap_done), 0);
    endtask

    task automatic put(input logic [7:0] x, input logic [7:0] y, input logic [11:0] rgb);
        logic rdy;
        int   guard = 0;
        wr_if.iWR_VALID = 1'b1;
        wr_if.iWR_X = x; wr_if.iWR_Y = y; wr_if.iWR_RGB = rgb;
        do begin
            rdy = wr_if.oWR_READY;
            tick;
            guard++;
        end while (!rdy && guard < 200);
        wr_if.iWR_VALID = 1'b0;
        if (rdy) mdl[1-mfront][{y, x}] = rgb;
        else chk("write_accept_timeout", 0, 1);
    endtask

    task automatic do_swap(input logic req, input logic expect_done);
        swap_req = req; frame_start = 1'b1;
        tick;
        swap_req = 1'b0; frame_start = 1'b0;
        chk("swap_done_pulse", 32'(swap_done), 32'(expect_done));
        tick;
        chk("swap_done_single", 32'(swap_done), 0);
        if (expect_done) mfront = 1 - mfront;
    endtask

    task automatic read_one(input logic [7:0] x, input logic [7:0] y,
                            output logic v, output logic [29:0] p);
        rd_en = 1'b1; rd_x = x; rd_y = y;
        tick;
        rd_en = 1'b0;
        tick;
        v = rd_valid;
        p = {pix_r, pix_g, pix_b};
    endtask

    task automatic run_reads(input string name);
        int n = qx.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin rd_en = 1'b1; rd_x = qx[i]; rd_y = qy[i]; end
            else rd_en = 1'b0;
            tick;
            if (i >= 1) begin
                chk({name, "_valid"}, 32'(rd_valid), 1);
                chk({name, "_pix"}, 32'({pix_r, pix_g, pix_b}),
                    32'(exp_pix(mdl[mfront][{qy[i-1], qx[i-1]}])));
            end
        end
        tick;
        chk({name, "_valid_off"}, 32'(rd_valid), 0);
        chk({name, "_pix_off"}, 32'({pix_r, pix_g, pix_b}), 0);
        qx.delete(); qy.delete();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        logic        v, rdy;
        logic [29:0] p;
        int          bad_ready;
        logic [15:0] a;

        tbl[0] = '{x: 8'd0,   y: 8'd0,   rgb: 12'h123, pix: {10'h044, 10'h088, 10'h0CC}};
        tbl[1] = '{x: 8'd255, y: 8'd255, rgb: 12'h8A5, pix: {10'h222, 10'h2AA, 10'h155}};
        tbl[2] = '{x: 8'd255, y: 8'd0,   rgb: 12'hFFF, pix: {10'h3FF, 10'h3FF, 10'h3FF}};
        tbl[3] = '{x: 8'd0,   y: 8'd255, rgb: 12'h4C7, pix: {10'h111, 10'h333, 10'h1DD}};
        tbl[4] = '{x: 8'd128, y: 8'd64,  rgb: 12'h000, pix: 30'h0};
        tbl[5] = '{x: 8'd7,   y: 8'd9,   rgb: 12'hF80, pix: {10'h3FF, 10'h222, 10'h000}};

        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 65536; i++) mdl[b][i] = '0;
        wr_if.iWR_VALID = 1'b0; wr_if.iWR_X = '0; wr_if.iWR_Y = '0; wr_if.iWR_RGB = '0;

        // Reset and first read latency
        repeat (3) tick;
        rst = 1'b0;
        tick;
        chk_idle_outputs("reset");
        rd_en = 1'b1; rd_x = 8'd0; rd_y = 8'd0;
        tick;
        rd_en = 1'b0;
        chk("lat_t1_valid", 32'(rd_valid), 0);
        tick;
        chk("lat_t2_valid", 32'(rd_valid), 1);
        chk("lat_t2_pix", 32'({pix_r, pix_g, pix_b}), 0);
        tick;
        chk("lat_t3_valid", 32'(rd_valid), 0);

        // Single write, separate swap request, then frame start
        put(8'd10, 8'd20, 12'hF80);
        chk("wr_busy_e0", 32'(busy), 1);
        tick;
        chk("wr_busy_e1", 32'(busy), 1);
        tick;
        chk("wr_busy_e2", 32'(busy), 0);
        swap_req = 1'b1;
        tick;
        swap_req = 1'b0;
        chk("swap_req_only", 32'(swap_done), 0);
        do_swap(1'b0, 1'b1);
        read_one(8'd10, 8'd20, v, p);
        chk("px_10_20_valid", 32'(v), 1);
        chk("px_10_20", 32'(p), 32'({10'h3FF, 10'h222, 10'h000}));

        // Back-to-back burst; a frame start mid-burst must not swap
        swap_req = 1'b1;
        tick;
        swap_req = 1'b0;
        wr_if.iWR_VALID = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_if.iWR_X = tbl[i].x; wr_if.iWR_Y = tbl[i].y; wr_if.iWR_RGB = tbl[i].rgb;
            frame_start = (i == 3);
            rdy = wr_if.oWR_READY;
            chk("burst_ready", 32'(rdy), 1);
            tick;
            frame_start = 1'b0;
            if (i == 3) chk("burst_no_swap", 32'(swap_done), 0);
            if (rdy) mdl[1-mfront][{tbl[i].y, tbl[i].x}] = tbl[i].rgb;
        end
        wr_if.iWR_VALID = 1'b0;
        tick; tick;
        chk("burst_drained", 32'(busy), 0);
        do_swap(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            read_one(tbl[i].x, tbl[i].y, v, p);
            chk("tbl_valid", 32'(v), 1);
            chk("tbl_pix", 32'(p), 32'(tbl[i].pix));
        end

        // Full clear with a write held off and a blocked swap
        clear_req = 1'b1; clear_rgb = 12'h00F;
        tick;
        clear_req = 1'b0; clear_rgb = 12'hFFF;
        chk("clr_ready_low", 32'(wr_if.oWR_READY), 0);
        chk("clr_busy", 32'(busy), 1);
        wr_if.iWR_VALID = 1'b1; wr_if.iWR_X = 8'd5; wr_if.iWR_Y = 8'd5; wr_if.iWR_RGB = 12'hABC;
        bad_ready = 0;
        for (int j = 1; j <= 65537; j++) begin
            if (j == 999) begin swap_req = 1'b1; frame_start = 1'b1; end
            tick;
            if (j == 999) begin swap_req = 1'b0; frame_start = 1'b0; end
            if (j == 1000) chk("clr_no_swap", 32'(swap_done), 0);
            if (wr_if.oWR_READY !== (j == 65537)) bad_ready++;
            if (j == 65536) chk("clr_busy_last", 32'(busy), 1);
            if (j == 65537) chk("clr_busy_done", 32'(busy), 0);
        end
        chk("clr_ready_gate", 32'(bad_ready), 0);
        tick;
        wr_if.iWR_VALID = 1'b0;
        for (int i = 0; i < 65536; i++) mdl[1-mfront][i] = 12'h00F;
        mdl[1-mfront][{8'd5, 8'd5}] = 12'hABC;
        tick; tick;
        chk("clr_wr_drained", 32'(busy), 0);
        do_swap(1'b0, 1'b1);
        read_one(8'd0, 8'd0, v, p);
        chk("clr_px_0_0", 32'(p), 32'({10'h000, 10'h000, 10'h3FF}));
        read_one(8'd255, 8'd255, v, p);
        chk("clr_px_255_255", 32'(p), 32'({10'h000, 10'h000, 10'h3FF}));
        qx.push_back(8'd5); qy.push_back(8'd5);
        qx.push_back(8'd4); qy.push_back(8'd5);
        for (int i = 0; i < 6; i++) begin
            qx.push_back(8'($urandom)); qy.push_back(8'($urandom));
        end
        run_reads("clr_reads");

        // Reset part-way through a clear of the other bank
        clear_req = 1'b1; clear_rgb = 12'h0F0;
        tick;
        clear_req = 1'b0;
        repeat (3000) tick;
        rst = 1'b1;
        tick;
        chk_idle_outputs("midclr_reset");
        rst = 1'b0;
        tick;
        for (int i = 0; i <= 2998; i++) mdl[1-mfront][i] = 12'h0F0;
        mfront = 0;
        a = 16'd2998; qx.push_back(a[7:0]); qy.push_back(a[15:8]);
        a = 16'd2999; qx.push_back(a[7:0]); qy.push_back(a[15:8]);
        qx.push_back(8'd0); qy.push_back(8'd0);
        qx.push_back(8'd7); qy.push_back(8'd9);
        run_reads("reset_reads");

        // Randomized writes, combined swap request + frame start, random reads
        for (int i = 0; i < 24; i++) begin
            logic [7:0] x = 8'($urandom);
            logic [7:0] y = 8'($urandom_range(0, 15));
            put(x, y, 12'($urandom));
            qx.push_back(x); qy.push_back(y);
            repeat ($urandom_range(0, 2)) tick;
        end
        tick; tick;
        chk("rand_drained", 32'(busy), 0);
        do_swap(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            qx.push_back(8'($urandom)); qy.push_back(8'($urandom));
        end
        run_reads("rand_reads");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
